// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
//   Groups the hazard inputs, the data-memory handshake and the per-stage
//   stall/flush controls exchanged between the pipeline and its hazard
//   sequencer.
//   Modports:
//     master - the hazard controller: samples hazard/handshake inputs,
//              drives dmem_valid, muldiv_done, PC and register controls.
//     slave  - the pipeline datapath: the mirror image of master.
interface pipe_hazard_ctrl_if;
    logic if_wait;
    logic load_use;
    logic ex_muldiv;
    logic ex_redirect;
    logic mem_req;
    logic dmem_data_ok;
    logic dmem_valid;
    logic muldiv_done;
    logic pc_en;
    logic pc_redirect;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic ex_mem_flush;
    logic mem_wb_stall;
    logic mem_wb_flush;

    modport master (
        input  if_wait, load_use, ex_muldiv, ex_redirect, mem_req, dmem_data_ok,
        output dmem_valid, muldiv_done, pc_en, pc_redirect,
               if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush
    );

    modport slave (
        output if_wait, load_use, ex_muldiv, ex_redirect, mem_req, dmem_data_ok,
        input  dmem_valid, muldiv_done, pc_en, pc_redirect,
               if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Stall/flush sequencer for the five-stage pipeline. Owns the data-memory
//   request handshake (MEM FSM), the multicycle mul/div occupancy counter
//   (EX FSM) and tracking of fetches killed by a redirect while in flight.
//   Register semantics downstream: flush beats stall beats enable.
//   Ports:
//     clk   - clock
//     reset - synchronous active-high reset; forces all flushes while high
//     hz    - pipe_hazard_ctrl_if.master: hazard inputs, dmem handshake,
//             PC and inter-stage register stall/flush controls
module pipe_hazard_ctrl #(
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.master hz
);

    typedef enum logic { M_IDLE, M_WAIT } mstate_t;
    typedef enum logic [1:0] { E_IDLE, E_BUSY, E_DONE } estate_t;

    localparam logic [3:0] CNT_LOAD = 4'(MULDIV_LAT - 2);

    mstate_t    m_state, m_next;
    estate_t    e_state, e_next;
    logic [3:0] cnt, cnt_next;
    logic       kill_pend, kill_next;

    logic mem_hold, ex_busy, ex_hold, id_hold, if_hold, take;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_state   <= M_IDLE;
            e_state   <= E_IDLE;
            cnt       <= '0;
            kill_pend <= 1'b0;
        end else begin
            m_state   <= m_next;
            e_state   <= e_next;
            cnt       <= cnt_next;
            kill_pend <= kill_next;
        end
    end

    always_comb begin
        m_next    = m_state;
        e_next    = e_state;
        cnt_next  = cnt;
        kill_next = kill_pend;

        mem_hold = hz.mem_req & ~hz.dmem_data_ok;
        ex_busy  = ((e_state == E_IDLE) & hz.ex_muldiv) | (e_state == E_BUSY);
        ex_hold  = mem_hold | ex_busy;
        id_hold  = ex_hold | hz.load_use;
        if_hold  = id_hold | hz.if_wait;
        take     = hz.ex_redirect & ~ex_hold;

        case (m_state)
            M_IDLE:  if (mem_hold) m_next = M_WAIT;
            M_WAIT:  if (hz.dmem_data_ok) m_next = M_IDLE;
            default: m_next = M_IDLE;
        endcase

        // The busy window is the accepting E_IDLE cycle plus MULDIV_LAT-2
        // E_BUSY cycles; E_BUSY is left as cnt steps down to zero, and with
        // MULDIV_LAT==2 there is nothing to count so E_BUSY is skipped.
        case (e_state)
            E_IDLE: begin
                if (hz.ex_muldiv) begin
                    cnt_next = CNT_LOAD;
                    e_next   = (CNT_LOAD == 4'd0) ? E_DONE : E_BUSY;
                end
            end
            E_BUSY: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) e_next = E_DONE;
            end
            E_DONE: begin
                // Stay until EX actually advances so the op is not restarted.
                if (!mem_hold) e_next = E_IDLE;
            end
            default: e_next = E_IDLE;
        endcase

        if (take & hz.if_wait) kill_next = 1'b1;
        else if (!hz.if_wait)  kill_next = 1'b0;

        hz.dmem_valid   = (m_state == M_WAIT) | hz.mem_req;
        hz.muldiv_done  = (e_state == E_DONE);
        hz.pc_redirect  = take;
        hz.pc_en        = ~if_hold | take;
        hz.mem_wb_stall = 1'b0;
        hz.mem_wb_flush = mem_hold;
        hz.ex_mem_stall = mem_hold;
        hz.ex_mem_flush = ex_busy & ~mem_hold;
        hz.id_ex_stall  = ex_hold;
        hz.id_ex_flush  = ~ex_hold & (hz.load_use | take);
        hz.if_id_stall  = id_hold & ~take;
        hz.if_id_flush  = take | (~id_hold & (hz.if_wait | kill_pend));

        if (reset) begin
            hz.dmem_valid   = 1'b0;
            hz.muldiv_done  = 1'b0;
            hz.pc_redirect  = 1'b0;
            hz.pc_en        = 1'b0;
            hz.mem_wb_stall = 1'b0;
            hz.mem_wb_flush = 1'b1;
            hz.ex_mem_stall = 1'b0;
            hz.ex_mem_flush = 1'b1;
            hz.id_ex_stall  = 1'b0;
            hz.id_ex_flush  = 1'b1;
            hz.if_id_stall  = 1'b0;
            hz.if_id_flush  = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl (MULDIV_LAT=4). Each step drives
//   {reset, if_wait, load_use, ex_muldiv, ex_redirect, mem_req, dmem_data_ok}
//   and compares the 12 outputs, packed as
//   {dmem_valid, muldiv_done, pc_en, pc_redirect,
//    if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
//    ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush},
//   against hand-computed values.
module tb_pipe_hazard_ctrl;
    logic clk;
    logic reset;
    int   nchk;
    int   nfail;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(.MULDIV_LAT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input pattern encodings
    localparam logic [6:0] I_RST  = 7'b1000000;
    localparam logic [6:0] I_NONE = 7'b0000000;
    localparam logic [6:0] I_IFW  = 7'b0100000;
    localparam logic [6:0] I_LU   = 7'b0010000;
    localparam logic [6:0] I_MD   = 7'b0001000;
    localparam logic [6:0] I_RED  = 7'b0000100;
    localparam logic [6:0] I_REQ  = 7'b0000010;
    localparam logic [6:0] I_OK   = 7'b0000001;

    function automatic logic [11:0] obs_vec();
        return {hz.dmem_valid, hz.muldiv_done, hz.pc_en, hz.pc_redirect,
                hz.if_id_stall, hz.if_id_flush, hz.id_ex_stall, hz.id_ex_flush,
                hz.ex_mem_stall, hz.ex_mem_flush, hz.mem_wb_stall, hz.mem_wb_flush};
    endfunction

    task automatic step(input logic [6:0] in, input logic [11:0] exp, input string tag);
        logic [11:0] obs;
        reset           = in[6];
        hz.if_wait      = in[5];
        hz.load_use     = in[4];
        hz.ex_muldiv    = in[3];
        hz.ex_redirect  = in[2];
        hz.mem_req      = in[1];
        hz.dmem_data_ok = in[0];
        #1;
        obs = obs_vec();
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pair_chk(input string tag, input logic s, input logic f);
        nchk++;
        assert ((s & f) === 1'b0) else begin
            nfail++;
            $error("FAIL %s: stall=%b flush=%b observed both, required not both", tag, s, f);
        end
    endtask

    always @(negedge clk) begin
        pair_chk("if_id_pair",  hz.if_id_stall,  hz.if_id_flush);
        pair_chk("id_ex_pair",  hz.id_ex_stall,  hz.id_ex_flush);
        pair_chk("ex_mem_pair", hz.ex_mem_stall, hz.ex_mem_flush);
        pair_chk("mem_wb_pair", hz.mem_wb_stall, hz.mem_wb_flush);
    end

    initial begin
        nchk  = 0;
        nfail = 0;
        reset = 1'b1;
        hz.if_wait = 1'b0; hz.load_use = 1'b0; hz.ex_muldiv = 1'b0;
        hz.ex_redirect = 1'b0; hz.mem_req = 1'b0; hz.dmem_data_ok = 1'b0;
        @(posedge clk);
        #1;

        // Reset forcing, including with live inputs
        step(I_RST,                 12'h055, "reset_idle");
        step(I_RST | I_REQ | I_MD,  12'h055, "reset_forced");
        step(I_NONE,                12'h200, "idle");

        // Load with three wait cycles
        step(I_REQ,                 12'h8A9, "load_w1");
        step(I_REQ,                 12'h8A9, "load_w2");
        step(I_REQ,                 12'h8A9, "load_w3");
        step(I_REQ | I_OK,          12'hA00, "load_done");
        step(I_NONE,                12'h200, "load_no_reissue");

        // Mul/div into idle EX
        step(I_MD,                  12'h0A4, "md_s1");
        step(I_NONE,                12'h0A4, "md_s2");
        step(I_NONE,                12'h0A4, "md_s3");
        step(I_NONE,                12'h600, "md_done");
        step(I_NONE,                12'h200, "md_idle");

        // Mul/div finishing under a 2-cycle MEM hold
        step(I_MD,                  12'h0A4, "mdh_s1");
        step(I_NONE,                12'h0A4, "mdh_s2");
        step(I_NONE,                12'h0A4, "mdh_s3");
        step(I_REQ,                 12'hCA9, "mdh_done_hold1");
        step(I_REQ,                 12'hCA9, "mdh_done_hold2");
        step(I_REQ | I_OK,          12'hE00, "mdh_done_adv");
        step(I_NONE,                12'h200, "mdh_no_recount");

        // Single-cycle load-use
        step(I_LU,                  12'h090, "load_use");
        step(I_NONE,                12'h200, "load_use_end");

        // Redirect while fetch outstanding; killed fetch flushed on return
        step(I_RED | I_IFW,         12'h350, "redir_ifwait");
        step(I_IFW,                 12'h040, "kill_wait");
        step(I_NONE,                12'h240, "kill_return");
        step(I_NONE,                12'h200, "kill_cleared");

        // Redirect beats load-use
        step(I_RED | I_LU,          12'h350, "redir_lu");
        step(I_NONE,                12'h200, "redir_lu_end");

        // Redirect deferred by MEM hold
        step(I_RED | I_REQ,         12'h8A9, "redir_deferred");
        step(I_RED | I_REQ | I_OK,  12'hB50, "redir_taken");
        step(I_NONE,                12'h200, "redir_def_end");

        // Reset in M_WAIT with E_BUSY cnt=2
        step(I_MD | I_REQ,          12'h8A9, "pre_reset_busy");
        step(I_RST | I_REQ,         12'h055, "mid_reset");
        step(I_NONE,                12'h200, "post_reset_clean");
        step(I_MD,                  12'h0A4, "post_md_s1");
        step(I_NONE,                12'h0A4, "post_md_s2");
        step(I_NONE,                12'h0A4, "post_md_s3");
        step(I_NONE,                12'h600, "post_md_done");

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the five-stage pipeline. Drives hold (stall) and bubble (flush) controls for the four inter-stage registers (if_id, id_ex, ex_mem, mem_wb) and the PC.
- Owns the data-memory request handshake and the multicycle mul/div occupancy counter.
- Tracks fetches that are killed by a redirect while still in flight.

Parameters:
- MULDIV_LAT, 4, total EX cycles occupied by a mul/div op (legal range 2..16).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- if_wait  in  1  instruction fetch not yet returned this cycle
- load_use  in  1  ID instruction depends on a load currently in EX
- ex_muldiv  in  1  EX holds a valid mul/div op
- ex_redirect  in  1  EX branch/jump mispredicted; new PC valid
- mem_req  in  1  MEM holds a valid load/store
- dmem_data_ok  in  1  data memory completes the outstanding access
- dmem_valid  out  1  data memory request valid
- muldiv_done  out  1  mul/div result valid in EX
- pc_en  out  1  PC register update enable
- pc_redirect  out  1  select redirect target into PC
- if_id_stall, if_id_flush  out  1 each
- id_ex_stall, id_ex_flush  out  1 each
- ex_mem_stall, ex_mem_flush  out  1 each
- mem_wb_stall, mem_wb_flush  out  1 each

Behaviour:
- Register semantics: flush beats stall beats enable. The controller never asserts stall and flush together on one register.
- Reset (synchronous): MEM FSM to M_IDLE; EX FSM to E_IDLE with cnt=0; kill_pend=0.
- While reset=1, outputs are forced: all *_flush=1, all *_stall=0, pc_en=0, pc_redirect=0, dmem_valid=0, muldiv_done=0.
- A reset asserted mid-operation abandons any wait or count. The next cycle starts clean.
- MEM FSM (states M_IDLE, M_WAIT):
  - dmem_valid = mem_req in M_IDLE; dmem_valid = 1 in M_WAIT.
  - M_IDLE: mem_req & !dmem_data_ok -> M_WAIT. mem_req & dmem_data_ok completes in the same cycle (zero wait).
  - M_WAIT: dmem_data_ok -> M_IDLE.
  - mem_hold = mem_req & !dmem_data_ok (either state).
- EX FSM (states E_IDLE, E_BUSY, E_DONE):
  - E_IDLE: ex_muldiv -> E_BUSY, cnt = MULDIV_LAT-2.
  - E_BUSY: cnt decrements each cycle. At cnt==0 -> E_DONE.
  - E_DONE: muldiv_done=1. Leaves to E_IDLE only when EX advances (!mem_hold). Otherwise it holds, so the op is never restarted.
  - ex_busy = (E_IDLE & ex_muldiv) | E_BUSY.
  - An op entering EX therefore stalls exactly MULDIV_LAT-1 cycles, then has muldiv_done for at least 1 cycle.
- Stall chain, applied backward:
  - ex_hold = mem_hold | ex_busy
  - id_hold = ex_hold | load_use
  - if_hold = id_hold | if_wait
- Redirect: take = ex_redirect & !ex_hold. pc_redirect = take. pc_en = !if_hold | take.
- Kill tracking:
  - take & if_wait sets kill_pend.
  - kill_pend clears on the first cycle with !if_wait.
  - While kill_pend=1, the returning fetch is discarded.
- Register controls:
  - mem_wb_stall = 0. mem_wb_flush = mem_hold.
  - ex_mem_stall = mem_hold. ex_mem_flush = ex_busy & !mem_hold.
  - id_ex_stall = ex_hold. id_ex_flush = !ex_hold & (load_use | take).
  - if_id_stall = id_hold & !take.
  - if_id_flush = take | (!id_hold & (if_wait | kill_pend)).
- Simultaneous events: ex_redirect together with load_use gives the redirect priority in ID/IF (bubbles, no stall). A redirect during mem_hold is deferred until MEM completes; the EX register holds the branch meanwhile.

Test Plan:
- Reset, then load with mem_req=1 and dmem_data_ok low for 3 cycles -> dmem_valid high for 4 cycles. ex_mem_stall=1 and mem_wb_flush=1 for 3 cycles. FSM back to M_IDLE. No reissue.
- MULDIV_LAT=4, ex_muldiv pulse into an idle EX -> id_ex_stall=1 for 3 cycles, ex_mem_flush=1 for 3 cycles, muldiv_done=1 on cycle 4.
- Mul/div completes while mem_hold=1 for 2 extra cycles -> E_DONE held, muldiv_done=1 for 3 cycles, no recount.
- load_use=1 for 1 cycle with no other hazard -> if_id_stall=1, id_ex_flush=1, pc_en=0 for exactly 1 cycle.
- ex_redirect=1 while if_wait=1 -> pc_redirect=1 and both if_id_flush and id_ex_flush=1 that cycle. kill_pend set. The next returned fetch is flushed.
- Reset asserted in M_WAIT with E_BUSY cnt=2 -> next cycle both FSMs idle, cnt=0, all stalls 0. A per-register assertion checks stall&flush never both 1.
